// File: rtl/ysyx_rnu_pkg.sv
// rtl/ysyx_rnu_pkg.sv - shared sizes, retire FSM state and restore beat type
package ysyx_rnu_pkg;

   localparam int RNUM = 32;
   localparam int PNUM = 60;
   localparam int RLEN = 5;
   localparam int PLEN = 6;

   typedef logic [RLEN-1:0] ar_t;
   typedef logic [PLEN-1:0] pr_t;

   localparam ar_t LAST_AR = ar_t'(RNUM - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } retire_state_e;

   typedef struct packed {
      ar_t ar;
      pr_t pr;
   } rst_beat_t;

endpackage

// File: rtl/ysyx_rnu_retire_if.sv
// rtl/ysyx_rnu_retire_if.sv - commit/flush inputs, dealloc and restore outputs of the retire map
interface ysyx_rnu_retire_if;
   import ysyx_rnu_pkg::*;

   logic cmt_valid;
   ar_t  cmt_rd;
   pr_t  cmt_prd;
   logic flush_pipe;
   logic dealloc_req;
   pr_t  dealloc_pr;
   ar_t  flush_rd;
   logic rst_valid;
   ar_t  rst_ar;
   pr_t  rst_pr;
   logic busy;

   modport master (
      output cmt_valid, cmt_rd, cmt_prd, flush_pipe,
      input  dealloc_req, dealloc_pr, flush_rd, rst_valid, rst_ar, rst_pr, busy
   );

   modport slave (
      input  cmt_valid, cmt_rd, cmt_prd, flush_pipe,
      output dealloc_req, dealloc_pr, flush_rd, rst_valid, rst_ar, rst_pr, busy
   );

endinterface

// File: rtl/ysyx_rnu_rmt.sv
// rtl/ysyx_rnu_rmt.sv - retired map table: two async reads, one write, identity on reset
module ysyx_rnu_rmt
   import ysyx_rnu_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  ar_t  dl_raddr,
   output pr_t  dl_rdata,
   input  ar_t  rs_raddr,
   output pr_t  rs_rdata,
   input  logic we,
   input  ar_t  waddr,
   input  pr_t  wdata
);

   pr_t map_q [RNUM];
   pr_t map_d [RNUM];

   // Entry 0 is pinned to PR 0 and never rebinds.
   always_comb begin
      map_d = map_q;
      if (we && waddr != '0) begin
         map_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RNUM; i++) begin
            map_q[i] <= pr_t'(i);
         end
      end else begin
         map_q <= map_d;
      end
   end

   assign dl_rdata = map_q[dl_raddr];
   assign rs_rdata = map_q[rs_raddr];

endmodule

// File: rtl/ysyx_rnu_retire.sv
// rtl/ysyx_rnu_retire.sv - retired RAT: frees old PRs on commit, streams map to rename after flush
module ysyx_rnu_retire
   import ysyx_rnu_pkg::*;
#(
   parameter bit CHK_CMT_IN_RESTORE = 1'b1
)
(
   input logic               clock,
   input logic               reset,
   ysyx_rnu_retire_if.slave  io
);

   retire_state_e state_q, state_d;
   ar_t           idx_q, idx_d;
   pr_t           dl_rdata;
   pr_t           rs_rdata;
   rst_beat_t     beat;
   logic          busy;

   ysyx_rnu_rmt u_rmt (
      .clock    (clock),
      .reset    (reset),
      .dl_raddr (io.cmt_rd),
      .dl_rdata (dl_rdata),
      .rs_raddr (idx_q),
      .rs_rdata (rs_rdata),
      .we       (io.dealloc_req),
      .waddr    (io.cmt_rd),
      .wdata    (io.cmt_prd)
   );

   // Dealloc must land in the commit cycle; the free list counts in-flight PRs that way.
   assign io.dealloc_req = io.cmt_valid && (io.cmt_rd != '0) && (state_q == IDLE);
   assign io.dealloc_pr  = io.dealloc_req ? dl_rdata : '0;
   assign io.flush_rd    = (io.flush_pipe && io.cmt_valid) ? io.cmt_rd : '0;

   assign busy    = (state_q == RESTORE);
   assign beat.ar = busy ? idx_q : '0;
   assign beat.pr = busy ? rs_rdata : '0;

   assign io.busy      = busy;
   assign io.rst_valid = busy;
   assign io.rst_ar    = beat.ar;
   assign io.rst_pr    = beat.pr;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (io.flush_pipe) begin
               state_d = RESTORE;
               idx_d   = ar_t'(1);
            end
         end
         RESTORE: begin
            // A fresh flush simply replays the walk from entry 1.
            if (io.flush_pipe) begin
               idx_d = ar_t'(1);
            end else if (idx_q == LAST_AR) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && io.cmt_valid) begin
         assert (int'(io.cmt_prd) < PNUM);
         assert (io.cmt_rd == '0 || io.cmt_prd != '0);
         assert (!CHK_CMT_IN_RESTORE || state_q == IDLE);
      end
   end

endmodule

// File: tb/tb_ysyx_rnu_retire.sv
// tb/tb_ysyx_rnu_retire.sv - scoreboard bench for the retired map / restore walker
module tb_ysyx_rnu_retire;
   import ysyx_rnu_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ysyx_rnu_retire_if bus ();

   ysyx_rnu_retire #(.CHK_CMT_IN_RESTORE(1'b0)) dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   pr_t       dl_q [$];
   rst_beat_t rs_q [$];
   ar_t       fr_q [$];
   int        bl_q [$];
   pr_t       want [RNUM];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input bit cv, input int rd, input int prd, input bit fl);
      @(posedge clock);
      #1;
      bus.cmt_valid  = cv;
      bus.cmt_rd     = ar_t'(rd);
      bus.cmt_prd    = pr_t'(prd);
      bus.flush_pipe = fl;
   endtask

   task automatic push_walk(input int first, input int last);
      rst_beat_t b;
      for (int a = first; a <= last; a++) begin
         b.ar = ar_t'(a);
         b.pr = want[a];
         rs_q.push_back(b);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((dl_q.size() + rs_q.size() + fr_q.size() + bl_q.size()) != 0 && n < 200) begin
         cyc(1'b0, 0, 0, 1'b0);
         n++;
      end
      chk("drain_within_budget", 32'(n < 200), 32'd1);
   endtask

   // Monitor: pops expected responses whenever the DUT presents them.
   initial begin
      int run = 0;
      rst_beat_t e;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (bus.dealloc_req) begin
               if (dl_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_dealloc actual=req1 pr=%0d required=no_req", bus.dealloc_pr);
               end else begin
                  chk("dealloc_pr", bus.dealloc_pr, dl_q.pop_front());
               end
            end else begin
               chk("dealloc_pr_zero_when_idle", bus.dealloc_pr, 0);
            end
            if (bus.flush_pipe) begin
               if (fr_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unplanned_flush actual=flush_rd=%0d required=none", bus.flush_rd);
               end else begin
                  chk("flush_rd", bus.flush_rd, fr_q.pop_front());
               end
            end else begin
               chk("flush_rd_zero", bus.flush_rd, 0);
            end
            if (bus.rst_valid) begin
               if (rs_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_restore actual=ar%0d required=none", bus.rst_ar);
               end else begin
                  e = rs_q.pop_front();
                  chk("rst_ar", bus.rst_ar, e.ar);
                  chk("rst_pr", bus.rst_pr, e.pr);
               end
            end
            if (bus.busy) begin
               run++;
            end else if (run != 0) begin
               if (bl_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_busy_run actual=%0d required=none", run);
               end else begin
                  chk("busy_run_length", run, bl_q.pop_front());
               end
               run = 0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bus.cmt_valid  = 1'b0;
      bus.cmt_rd     = '0;
      bus.cmt_prd    = '0;
      bus.flush_pipe = 1'b0;
      for (int i = 0; i < RNUM; i++) want[i] = pr_t'(i);

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_dealloc_req", bus.dealloc_req, 0);
      chk("reset_dealloc_pr", bus.dealloc_pr, 0);
      chk("reset_flush_rd", bus.flush_rd, 0);
      chk("reset_rst_valid", bus.rst_valid, 0);
      chk("reset_rst_ar", bus.rst_ar, 0);
      chk("reset_rst_pr", bus.rst_pr, 0);
      chk("reset_busy", bus.busy, 0);
      @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Back-to-back commits to one rd return the identity PR, then the first new PR.
      dl_q.push_back(pr_t'(5));
      cyc(1'b1, 5, 40, 1'b0);
      dl_q.push_back(pr_t'(40));
      cyc(1'b1, 5, 41, 1'b0);
      want[5] = pr_t'(41);

      // rd=0 commit: no dealloc, no map change.
      cyc(1'b1, 0, 33, 1'b0);
      cyc(1'b0, 0, 0, 1'b0);

      // Commit coinciding with flush; the walk sees the new binding.
      dl_q.push_back(pr_t'(3));
      fr_q.push_back(ar_t'(3));
      want[3] = pr_t'(50);
      push_walk(1, RNUM - 1);
      bl_q.push_back(RNUM - 1);
      cyc(1'b1, 3, 50, 1'b1);
      drain();

      // Second flush while ar=4 is on the stream restarts at ar=1.
      fr_q.push_back('0);
      push_walk(1, 4);
      cyc(1'b0, 0, 0, 1'b1);
      repeat (3) cyc(1'b0, 0, 0, 1'b0);
      fr_q.push_back('0);
      push_walk(1, RNUM - 1);
      bl_q.push_back(4 + RNUM - 1);
      cyc(1'b0, 0, 0, 1'b1);
      drain();

      // Commit during restore is ignored; ar=9 still restores as 9.
      fr_q.push_back('0);
      push_walk(1, RNUM - 1);
      bl_q.push_back(RNUM - 1);
      cyc(1'b0, 0, 0, 1'b1);
      cyc(1'b0, 0, 0, 1'b0);
      cyc(1'b1, 9, 44, 1'b0);
      drain();
      dl_q.push_back(pr_t'(9));
      cyc(1'b1, 9, 45, 1'b0);
      cyc(1'b0, 0, 0, 1'b0);

      // Reset in the middle of a walk.
      fr_q.push_back('0);
      push_walk(1, 3);
      bl_q.push_back(3);
      cyc(1'b0, 0, 0, 1'b1);
      repeat (2) cyc(1'b0, 0, 0, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset_busy", bus.busy, 0);
      chk("post_reset_rst_valid", bus.rst_valid, 0);
      dl_q.push_back(pr_t'(7));
      cyc(1'b1, 7, 47, 1'b0);
      dl_q.push_back(pr_t'(5));
      cyc(1'b1, 5, 42, 1'b0);
      dl_q.push_back(pr_t'(9));
      cyc(1'b1, 9, 46, 1'b0);
      drain();
      cyc(1'b0, 0, 0, 1'b0);
      @(negedge clock);
      chk("final_queues_empty", dl_q.size() + rs_q.size() + fr_q.size() + bl_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_rnu_retire.md
Name: ysyx_rnu_retire

Overview:
Commit-side counterpart of the rename free list. It holds the architectural (retired) register map table. On each committed instruction that writes a register it records the new physical register and frees the old one by driving the free list's dealloc interface. On a pipeline flush it drives the flush_rd accounting signal, then walks the retired map and streams it to the speculative RAT so rename can resume from committed state.

Parameters:
RNUM, `YSYX_REG_SIZE, number of architectural registers
PNUM, `YSYX_PHY_SIZE, number of physical registers
RLEN, `YSYX_REG_LEN, architectural register index width
PLEN, `YSYX_PHY_LEN, physical register index width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmt_valid  in  1  one instruction commits this cycle
cmt_rd  in  RLEN  architectural destination (0 = no destination)
cmt_prd  in  PLEN  physical register newly bound to cmt_rd
flush_pipe  in  1  pipeline flush, same cycle the free list sees it
dealloc_req  out  1  free-list release strobe
dealloc_pr  out  PLEN  physical register being released
flush_rd  out  RLEN  cmt_rd when a commit coincides with flush_pipe, else 0
rst_valid  out  1  restore stream entry valid
rst_ar  out  RLEN  architectural index being restored
rst_pr  out  PLEN  retired mapping for rst_ar
busy  out  1  restore in progress; rename must stall

Behaviour:
- Reset: map[i] = i for all i < RNUM. FSM = IDLE, walk index = 0. All outputs 0. Rename therefore starts with PRs 0..RNUM-1 architecturally live.
- Dealloc is combinational, in the same cycle as the commit:
  - dealloc_req = cmt_valid && cmt_rd != 0 && state == IDLE.
  - dealloc_pr = map[cmt_rd] (the old value). dealloc_pr = 0 whenever dealloc_req = 0.
  - Same-cycle timing is required because the free list's in-flight count relies on it.
- Map update on the clock edge when dealloc_req: map[cmt_rd] <= cmt_prd. map[0] is never written.
- flush_rd = (flush_pipe && cmt_valid) ? cmt_rd : 0, combinational. Commit and flush in the same cycle: the commit is fully applied (dealloc plus map write) before the walk starts.
- FSM:
  - IDLE: flush_pipe -> RESTORE, walk index <= 1.
  - RESTORE: one entry per cycle. rst_valid = 1, rst_ar = index, rst_pr = map[index]. index increments. After index RNUM-1 is emitted -> IDLE.
  - RESTORE duration is exactly RNUM-1 cycles. busy = (state == RESTORE).
  - Entry 0 is never streamed; the speculative RAT hardwires it.
- flush_pipe during RESTORE restarts the walk at index 1 next cycle. Any entries already sent are simply sent again.
- cmt_valid during RESTORE is illegal (the ROB is empty after a flush). It is ignored (no dealloc, no map write) and caught by an assertion.
- Index arithmetic is RLEN bits wide. The terminal compare is against RNUM-1, so there is no wrap.
- Reset in RESTORE returns to IDLE with the map reinitialised and rst_valid = 0 in the following cycle.
- Assertions:
  - cmt_prd < PNUM.
  - cmt_prd != 0 when cmt_rd != 0.

Decomposition:
- Shared package (ysyx_rnu_pkg): retire FSM enum {IDLE, RESTORE} and a typedef for the restore beat {ar, pr}.
- Map-table storage is natural as a sub-module, ysyx_rnu_rmt: 1 async read port for dealloc, 1 async read port for the restore walk, 1 write port, reset-to-identity.
- Control, dealloc and flush_rd logic stay in ysyx_rnu_retire.
- Dealloc outputs connect to the free list's rnu_fl_if dealloc_req/dealloc_pr/flush_rd fields.

Test Plan:
- Reset, then commit rd=5 prd=40 -> dealloc_req=1, dealloc_pr=5 that cycle; then commit rd=5 prd=41 -> dealloc_pr=40.
- Commit rd=0 prd=33 -> dealloc_req=0, dealloc_pr=0, map unchanged (later restore shows ar 1..RNUM-1 identity).
- Commit rd=3 prd=50 together with flush_pipe -> flush_rd=3, dealloc_pr=3. The next RNUM-1 cycles stream ar=1..RNUM-1 with ar=3 -> pr=50. busy high for exactly RNUM-1 cycles.
- Flush, then a second flush at walk index 4 -> the stream restarts at ar=1 the next cycle. busy stays high continuously and ends RNUM-1 cycles after the second flush.
- cmt_valid asserted during RESTORE -> no dealloc_req, map unchanged, assertion fires.
- Reset asserted mid-RESTORE -> the next cycle busy=0, rst_valid=0, and a commit rd=7 returns dealloc_pr=7.
